// File: rtl/mcu_result_collector_if.sv
// Handshake bundle between the convolver lanes, the result collector and the host.
// The slave side belongs to the collector; the master side is the lanes/host.
interface mcu_result_collector_if #(
  parameter int N_CONV      = 2,
  parameter int BITS_IMAGEN = 8
);
  logic [N_CONV*BITS_IMAGEN-1:0] i_DataConv;
  logic                          i_convValid;
  logic                          o_convReady;
  logic [3*BITS_IMAGEN-1:0]      o_Data;
  logic                          o_dataValid;
  logic                          i_dataAck;
  logic                          i_flush;
  logic                          o_overflow;

  modport slave (
    input  i_DataConv, i_convValid, i_dataAck, i_flush,
    output o_convReady, o_Data, o_dataValid, o_overflow
  );

  modport master (
    output i_DataConv, i_convValid, i_dataAck, i_flush,
    input  o_convReady, o_Data, o_dataValid, o_overflow
  );
endinterface

// File: rtl/mcu_result_collector.sv
// Gathers N_CONV convolver pixels per beat into a pixel FIFO and repacks them
// into 3-pixel host words (first pixel in the LSB byte), with flush and overflow.
module mcu_result_collector #(
  parameter int N_CONV      = 2,
  parameter int BITS_IMAGEN = 8,
  parameter int DEPTH       = 8
) (
  input logic i_CLK,
  input logic i_reset,
  mcu_result_collector_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = 3 * BITS_IMAGEN;

  // Pointer increment that also works for non-power-of-two depths.
  function automatic logic [PW-1:0] ptrAdd(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return s[PW-1:0];
  endfunction

  logic [BITS_IMAGEN-1:0] mem [DEPTH];
  logic [BITS_IMAGEN-1:0] inPix [N_CONV];

  logic [CW-1:0] countReg, countNext;
  logic [PW-1:0] wrPtrReg, wrPtrNext;
  logic [PW-1:0] rdPtrReg, rdPtrNext;
  logic [WW-1:0] dataReg, dataNext;
  logic          validReg, validNext;
  logic          overflowReg, overflowNext;

  logic                   convReady;
  logic                   pushEn;
  logic                   slotFree;
  logic [CW-1:0]          popped;
  logic [BITS_IMAGEN-1:0] rd0, rd1, rd2;

  generate
    for (genvar gi = 0; gi < N_CONV; gi++) begin : gLane
      assign inPix[gi] = bus.i_DataConv[gi*BITS_IMAGEN +: BITS_IMAGEN];
    end
  endgenerate

  // Ready depends only on registered count, so there is no path from the ack.
  assign convReady       = (countReg <= CW'(DEPTH - N_CONV));
  assign bus.o_convReady = convReady;
  assign bus.o_Data      = dataReg;
  assign bus.o_dataValid = validReg;
  assign bus.o_overflow  = overflowReg;

  always_comb begin
    pushEn       = bus.i_convValid && convReady;
    slotFree     = !validReg || bus.i_dataAck;
    rd0          = mem[rdPtrReg];
    rd1          = mem[ptrAdd(rdPtrReg, 1)];
    rd2          = mem[ptrAdd(rdPtrReg, 2)];
    popped       = '0;
    dataNext     = dataReg;
    validNext    = validReg;
    overflowNext = overflowReg | (bus.i_convValid && !convReady);

    if (slotFree && countReg >= CW'(3)) begin
      popped    = CW'(3);
      dataNext  = {rd2, rd1, rd0};
      validNext = 1'b1;
    end else if (slotFree && bus.i_flush && countReg != '0) begin
      // Only 1 or 2 pixels can remain here; unused upper bytes are zero.
      popped    = countReg;
      dataNext  = (countReg == CW'(1)) ? {{(2*BITS_IMAGEN){1'b0}}, rd0}
                                       : {{BITS_IMAGEN{1'b0}}, rd1, rd0};
      validNext = 1'b1;
    end else if (bus.i_dataAck) begin
      validNext = 1'b0;
    end

    countNext = countReg + (pushEn ? CW'(N_CONV) : CW'(0)) - popped;
    wrPtrNext = pushEn ? ptrAdd(wrPtrReg, N_CONV) : wrPtrReg;
    rdPtrNext = ptrAdd(rdPtrReg, int'(popped));
  end

  always_ff @(posedge i_CLK) begin
    if (!i_reset && pushEn) begin
      for (int k = 0; k < N_CONV; k++) begin
        mem[ptrAdd(wrPtrReg, k)] <= inPix[k];
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      countReg    <= '0;
      wrPtrReg    <= '0;
      rdPtrReg    <= '0;
      dataReg     <= '0;
      validReg    <= 1'b0;
      overflowReg <= 1'b0;
    end else begin
      countReg    <= countNext;
      wrPtrReg    <= wrPtrNext;
      rdPtrReg    <= rdPtrNext;
      dataReg     <= dataNext;
      validReg    <= validNext;
      overflowReg <= overflowNext;
    end
  end
endmodule
